// File: rtl/alu_arbiter_pkg.sv
// alu_defs: opcode constants and arbiter state encoding shared by the
// arbiter and the standalone datapath.
package alu_defs;
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
endpackage

// File: rtl/alu_arbiter_logic.sv
// alu_logic: combinational bitwise/add unit; carry is meaningful only for ADD.
module alu_logic
   import alu_defs::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             carry
);
   logic [WIDTH:0] sum;
   assign sum   = {1'b0, a} + {1'b0, b};
   assign y     = op == OP_AND ? a & b :
                  op == OP_OR  ? a | b :
                  op == OP_XOR ? a ^ b : sum[WIDTH-1:0];
   assign carry = (op == OP_ADD) & sum[WIDTH];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that serialises NREQ requesters onto one
// alu_logic instance and returns tagged results over a valid/ready port.
module alu_arbiter
   import alu_defs::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [IDW-1:0]        resp_id,
   output logic [WIDTH-1:0]      resp_data,
   output logic                  resp_carry
);
   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d, id_q, id_d, resp_id_q, resp_id_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, resp_data_q, resp_data_d;
   logic             resp_carry_q, resp_carry_d;
   logic             gnt_any;
   logic [IDW-1:0]   gnt_id;
   logic [WIDTH-1:0] alu_y;
   logic             alu_carry;
   logic [1:0]       op_arr [NREQ];
   logic [WIDTH-1:0] a_arr  [NREQ];
   logic [WIDTH-1:0] b_arr  [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign op_arr[i] = req_op[2*i +: 2];
      assign a_arr[i]  = req_a[WIDTH*i +: WIDTH];
      assign b_arr[i]  = req_b[WIDTH*i +: WIDTH];
   end

   // Scan downward so the candidate nearest to last+1 is written last and wins.
   always_comb begin
      logic [IDW-1:0] idx;
      idx     = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(last_q) + k) % NREQ);
         if (req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   alu_logic #(.WIDTH(WIDTH)) u_alu (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .y     (alu_y),
      .carry (alu_carry)
   );

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      resp_carry_d = resp_carry_q;
      if (state_q == ST_IDLE && gnt_any) begin
         state_d = ST_EXEC;
         last_d  = gnt_id;
         id_d    = gnt_id;
         op_d    = op_arr[gnt_id];
         a_d     = a_arr[gnt_id];
         b_d     = b_arr[gnt_id];
      end
      if (state_q == ST_EXEC) begin
         state_d      = ST_DONE;
         resp_id_d    = id_q;
         resp_data_d  = alu_y;
         resp_carry_d = alu_carry;
      end
      if (state_q == ST_DONE && resp_ready) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_q       <= IDW'(NREQ - 1);
         id_q         <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         resp_carry_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         id_q         <= id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_carry_q <= resp_carry_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE && gnt_any) ? NREQ'(1) << gnt_id : '0;
   assign resp_valid = state_q == ST_DONE;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_carry = resp_carry_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, corner-case sequences and a randomized
// run scored against a transaction-level round-robin/ALU reference.
module tb_alu_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] req_valid;
   logic [2*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_a, req_b;
   logic [NREQ-1:0] req_ready;
   logic            resp_valid, resp_ready, resp_carry;
   logic [1:0]      resp_id;
   logic [W-1:0]    resp_data;

   int n_tests = 0;
   int n_fail  = 0;

   alu_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_carry(resp_carry)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [1:0] op;
      logic [7:0] a, b, y;
      logic       c;
   } vec_t;
   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      int s;
      s = int'(a) + int'(b);
      if (op == 2'b00) return {1'b0, a & b};
      if (op == 2'b01) return {1'b0, a | b};
      if (op == 2'b10) return {1'b0, a ^ b};
      return {s >= 256, 8'(s % 256)};
   endfunction

   function automatic int ref_pick(input int last, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   task automatic clear_inputs();
      req_valid  = '0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]       = 1'b1;
      req_op[2*i +: 2]   = op;
      req_a[W*i +: W]    = a;
      req_b[W*i +: W]    = b;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      clear_inputs();
      set_req(v.id, v.op, v.a, v.b);
      #1;
      check("vec_ready", 32'(req_ready), 32'(1 << v.id));
      step();
      req_valid = '0;
      #1;
      check("vec_exec_ready", 32'(req_ready), 0);
      check("vec_exec_valid", 32'(resp_valid), 0);
      step();
      check("vec_valid", 32'(resp_valid), 1);
      check("vec_id", 32'(resp_id), 32'(v.id));
      check("vec_data", 32'(resp_data), 32'(v.y));
      check("vec_carry", 32'(resp_carry), 32'(v.c));
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      #1;
      check("vec_release", 32'(resp_valid), 0);
   endtask

   initial begin
      int g_ids [$];
      int g_cyc [$];
      logic [7:0] held;
      logic [NREQ-1:0] hold, exp_ready;
      int m_last, m_mode, m_id, pick;
      logic [8:0] m_res;

      vecs[0] = '{2, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
      vecs[1] = '{1, 2'b11, 8'hFF, 8'h02, 8'h01, 1'b1};
      vecs[2] = '{0, 2'b01, 8'hA0, 8'h05, 8'hA5, 1'b0};
      vecs[3] = '{3, 2'b10, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      vecs[4] = '{2, 2'b11, 8'h10, 8'h20, 8'h30, 1'b0};
      vecs[5] = '{0, 2'b11, 8'h80, 8'h80, 8'h00, 1'b1};

      clear_inputs();
      rst_n = 1'b0;
      step();
      check("rst_ready", 32'(req_ready), 0);
      check("rst_valid", 32'(resp_valid), 0);
      check("rst_id", 32'(resp_id), 0);
      check("rst_data", 32'(resp_data), 0);
      check("rst_carry", 32'(resp_carry), 0);
      step();
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // All requesters valid with resp_ready high: round-robin every 3 cycles.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 8'(i), 8'h10);
      resp_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin
               g_ids.push_back(i);
               g_cyc.push_back(c);
            end
         step();
      end
      check("rr_count", 32'(g_ids.size() >= 5), 1);
      for (int i = 0; i < 5 && i < g_ids.size(); i++) begin
         check("rr_order", 32'(g_ids[i]), 32'(i % NREQ));
         if (i > 0) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 3);
      end

      // Backpressure: DONE holds, no new grant until resp_ready rises.
      do_reset();
      set_req(3, 2'b11, 8'h33, 8'h44);
      #1;
      check("bp_first_grant", 32'(req_ready), 32'b1000);
      step();
      step();
      held = resp_data;
      check("bp_data", 32'(held), 32'h77);
      for (int c = 0; c < 5; c++) begin
         check("bp_valid_hold", 32'(resp_valid), 1);
         check("bp_data_hold", 32'(resp_data), 32'(held));
         check("bp_ready_zero", 32'(req_ready), 0);
         step();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_ready_during_hs", 32'(req_ready), 0);
      step();
      resp_ready = 1'b0;
      #1;
      check("bp_regrant", 32'(req_ready), 32'b1000);

      // Reset during EXEC discards the operation and restores priority to 0.
      do_reset();
      set_req(2, 2'b10, 8'hAA, 8'h55);
      #1;
      check("rx_grant", 32'(req_ready), 32'b0100);
      step();
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      check("rx_valid_in_rst", 32'(resp_valid), 0);
      check("rx_data_in_rst", 32'(resp_data), 0);
      step();
      check("rx_valid_in_rst2", 32'(resp_valid), 0);
      rst_n = 1'b1;
      step();
      check("rx_no_stale", 32'(resp_valid), 0);
      set_req(0, 2'b00, 8'h0F, 8'hFF);
      set_req(1, 2'b01, 8'h01, 8'h02);
      #1;
      check("rx_prio0", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      step();
      check("rx_resp_id", 32'(resp_id), 0);
      check("rx_resp_data", 32'(resp_data), 32'h0F);

      // Randomized run against the transaction-level reference.
      do_reset();
      hold   = '0;
      m_last = NREQ - 1;
      m_mode = 0;
      m_id   = 0;
      m_res  = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!hold[i]) begin
               req_valid[i]     = ($urandom_range(0, 1) == 1);
               req_op[2*i +: 2] = 2'($urandom_range(0, 3));
               req_a[W*i +: W]  = 8'($urandom_range(0, 255));
               req_b[W*i +: W]  = 8'($urandom_range(0, 255));
            end
         resp_ready = ($urandom_range(0, 2) != 0);
         #1;
         pick      = (m_mode == 0) ? ref_pick(m_last, req_valid) : -1;
         exp_ready = (pick >= 0) ? NREQ'(1) << pick : '0;
         check("rnd_ready", 32'(req_ready), 32'(exp_ready));
         check("rnd_valid", 32'(resp_valid), 32'(m_mode == 2));
         if (m_mode == 2) begin
            check("rnd_id", 32'(resp_id), 32'(m_id));
            check("rnd_data", 32'(resp_data), 32'(m_res[7:0]));
            check("rnd_carry", 32'(resp_carry), 32'(m_res[8]));
         end
         hold = req_valid & ~exp_ready;
         if (pick >= 0) begin
            m_id   = pick;
            m_last = pick;
            m_res  = ref_alu(req_op[2*pick +: 2], req_a[W*pick +: W], req_b[W*pick +: W]);
            m_mode = 1;
         end else if (m_mode == 1) m_mode = 2;
         else if (m_mode == 2 && resp_ready) m_mode = 0;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
